// File: rtl/conv_mem_host_if.sv
// rtl/conv_mem_host_if.sv - host/engine signal bundle for the convolution memory host
interface conv_mem_host_if #(
    parameter int DW = 20
);
    logic          start;
    logic          img_we;
    logic [11:0]   img_waddr;
    logic [DW-1:0] img_wdata;
    logic          ready;
    logic          busy;
    logic [11:0]   iaddr;
    logic [DW-1:0] idata;
    logic          cwr;
    logic [11:0]   caddr_wr;
    logic [DW-1:0] cdata_wr;
    logic [2:0]    csel;
    logic          crd;
    logic [11:0]   caddr_rd;
    logic [DW-1:0] cdata_rd;
    logic [2:0]    dbg_sel;
    logic [11:0]   dbg_addr;
    logic [DW-1:0] dbg_data;
    logic          done;
    logic          err;
    logic [13:0]   wr_count;

    modport master (
        output start, img_we, img_waddr, img_wdata, busy, iaddr,
               cwr, caddr_wr, cdata_wr, csel, crd, caddr_rd, dbg_sel, dbg_addr,
        input  ready, idata, cdata_rd, dbg_data, done, err, wr_count
    );

    modport slave (
        input  start, img_we, img_waddr, img_wdata, busy, iaddr,
               cwr, caddr_wr, cdata_wr, csel, crd, caddr_rd, dbg_sel, dbg_addr,
        output ready, idata, cdata_rd, dbg_data, done, err, wr_count
    );
endinterface

// File: rtl/conv_mem_host.sv
// rtl/conv_mem_host.sv - image/result memories and run sequencer for a convolution engine
module conv_mem_host #(
    parameter int IMG_DEPTH = 4096,
    parameter int DW        = 20
) (
    input  logic             clk,
    input  logic             reset,
    conv_mem_host_if.slave   bus
);
    typedef enum logic [1:0] {S_IDLE, S_ARM, S_RUN, S_DONE} state_t;

    // Memories carry no reset so a reset mid-run leaves results readable.
    logic [DW-1:0] image    [IMG_DEPTH];
    logic [DW-1:0] mem_l0k0 [4096];
    logic [DW-1:0] mem_l0k1 [4096];
    logic [DW-1:0] mem_l1k0 [1024];
    logic [DW-1:0] mem_l1k1 [1024];
    logic [DW-1:0] mem_l2   [2048];

    state_t      state_q, state_d;
    logic        ready_q, ready_d;
    logic        done_q, done_d;
    logic        err_q, err_d;
    logic [13:0] wr_count_q, wr_count_d;
    logic        wr_ok;
    logic        img_wr_ok;

    function automatic logic addr_ok(input logic [2:0] sel, input logic [11:0] addr);
        case (sel)
            3'd1, 3'd2: addr_ok = 1'b1;
            3'd3, 3'd4: addr_ok = (addr < 12'd1024);
            3'd5:       addr_ok = (addr < 12'd2048);
            default:    addr_ok = 1'b0;
        endcase
    endfunction

    function automatic logic [DW-1:0] rd_bank(input logic [2:0] sel, input logic [11:0] addr);
        case (sel)
            3'd1:    rd_bank = mem_l0k0[addr];
            3'd2:    rd_bank = mem_l0k1[addr];
            3'd3:    rd_bank = mem_l1k0[addr[9:0]];
            3'd4:    rd_bank = mem_l1k1[addr[9:0]];
            3'd5:    rd_bank = mem_l2[addr[10:0]];
            default: rd_bank = '0;
        endcase
    endfunction

    assign bus.idata    = (32'(bus.iaddr) < IMG_DEPTH) ? image[bus.iaddr] : '0;
    assign bus.cdata_rd = (bus.crd && addr_ok(bus.csel, bus.caddr_rd))
                          ? rd_bank(bus.csel, bus.caddr_rd) : '0;
    assign bus.dbg_data = addr_ok(bus.dbg_sel, bus.dbg_addr)
                          ? rd_bank(bus.dbg_sel, bus.dbg_addr) : '0;

    assign wr_ok     = bus.cwr && (state_q == S_RUN) && addr_ok(bus.csel, bus.caddr_wr);
    assign img_wr_ok = bus.img_we && (state_q == S_IDLE) && (32'(bus.img_waddr) < IMG_DEPTH);

    always_comb begin
        state_d    = state_q;
        ready_d    = ready_q;
        done_d     = 1'b0;
        err_d      = err_q;
        wr_count_d = wr_count_q;

        if (bus.img_we && state_q != S_IDLE)               err_d = 1'b1;
        if (bus.cwr && !wr_ok)                              err_d = 1'b1;
        if (bus.crd && !addr_ok(bus.csel, bus.caddr_rd))    err_d = 1'b1;
        if (wr_ok && wr_count_q != 14'h3FFF)                wr_count_d = wr_count_q + 14'd1;

        case (state_q)
            S_IDLE: begin
                ready_d = 1'b0;
                // An engine claiming to run without a request is a protocol fault.
                if (bus.busy) begin
                    err_d = 1'b1;
                end else if (bus.start) begin
                    state_d = S_ARM;
                    ready_d = 1'b1;
                end
            end
            S_ARM: begin
                if (bus.busy) begin
                    state_d    = S_RUN;
                    ready_d    = 1'b0;
                    err_d      = 1'b0;
                    wr_count_d = '0;
                end
            end
            S_RUN: begin
                if (!bus.busy) begin
                    state_d = S_DONE;
                    done_d  = 1'b1;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= S_IDLE;
            ready_q    <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            wr_count_q <= '0;
        end else begin
            state_q    <= state_d;
            ready_q    <= ready_d;
            done_q     <= done_d;
            err_q      <= err_d;
            wr_count_q <= wr_count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (img_wr_ok) image[bus.img_waddr] <= bus.img_wdata;
    end

    always_ff @(posedge clk) begin
        if (wr_ok) begin
            case (bus.csel)
                3'd1:    mem_l0k0[bus.caddr_wr]        <= bus.cdata_wr;
                3'd2:    mem_l0k1[bus.caddr_wr]        <= bus.cdata_wr;
                3'd3:    mem_l1k0[bus.caddr_wr[9:0]]   <= bus.cdata_wr;
                3'd4:    mem_l1k1[bus.caddr_wr[9:0]]   <= bus.cdata_wr;
                3'd5:    mem_l2[bus.caddr_wr[10:0]]    <= bus.cdata_wr;
                default: ;
            endcase
        end
    end

    assign bus.ready    = ready_q;
    assign bus.done     = done_q;
    assign bus.err      = err_q;
    assign bus.wr_count = wr_count_q;
endmodule
